instr_mem_loader: RTL and testbench

//  Writer side of the instruction memory that Simple_Single_CPU fetches from (cpu.IM.Instr_Mem).

---
 rtl/instr_mem_loader_pkg.sv | 48 ++++
 rtl/instr_mem_loader_if.sv | 23 ++
 rtl/instr_mem_loader_isa_check.sv | 24 ++
 rtl/instr_mem_loader.sv | 141 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared ISA constants and loader types for the instruction-memory loader.
// Opcodes are stored bit-inverted relative to classic MIPS encodings.
package instr_mem_loader_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned OP_W   = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b111111;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b110111;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b111011;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b110010;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b110000;

    localparam logic [OP_W-1:0] FUNC_ADD  = 6'b010010;
    localparam logic [OP_W-1:0] FUNC_SUB  = 6'b010000;
    localparam logic [OP_W-1:0] FUNC_AND  = 6'b010100;
    localparam logic [OP_W-1:0] FUNC_OR   = 6'b010110;
    localparam logic [OP_W-1:0] FUNC_SLT  = 6'b100000;
    localparam logic [OP_W-1:0] FUNC_SLLV = 6'b000110;
    localparam logic [OP_W-1:0] FUNC_SLL  = 6'b000000;
    localparam logic [OP_W-1:0] FUNC_SRLV = 6'b000100;
    localparam logic [OP_W-1:0] FUNC_SRL  = 6'b000010;
    localparam logic [OP_W-1:0] FUNC_NOR  = 6'b010101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_OPCODE   = 2'b01,
        ERR_FUNCT    = 2'b10,
        ERR_OVERFLOW = 2'b11
    } ld_err_e;

    function automatic logic [OP_W-1:0] opcode_of(input logic [WORD_W-1:0] w);
        return w[WORD_W-1 -: OP_W];
    endfunction

    function automatic logic [OP_W-1:0] funct_of(input logic [WORD_W-1:0] w);
        return w[OP_W-1:0];
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and IM write port of the loader, bundled as one bus.
interface instr_mem_loader_if
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
);
    logic [BYTE_W-1:0] byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              im_we_o;
    logic [ADDR_W-1:0] im_addr_o;
    logic [WORD_W-1:0] im_data_o;

    modport slave (
        input  byte_i, byte_valid_i,
        output byte_ready_o, im_we_o, im_addr_o, im_data_o
    );

    modport master (
        output byte_i, byte_valid_i,
        input  byte_ready_o, im_we_o, im_addr_o, im_data_o
    );
endinterface

// File: rtl/instr_mem_loader_isa_check.sv
// Combinational legality check of one instruction word: opcode set and R-type funct set.
module isa_legal_check
    import instr_mem_loader_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic              op_ok_c_o,
    output logic              funct_ok_c_o
);

    always_comb begin
        op_ok_c_o    = 1'b0;
        funct_ok_c_o = 1'b0;
        case (opcode_of(word_i))
            OP_RTYPE, OP_ADDI, OP_BEQ, OP_ORI, OP_LUI: op_ok_c_o = 1'b1;
            default: ;
        endcase
        case (funct_of(word_i))
            FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_SLT,
            FUNC_SLLV, FUNC_SLL, FUNC_SRLV, FUNC_SRL, FUNC_NOR: funct_ok_c_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Packs a byte stream into 32-bit words, writes them to the IM and
// releases the CPU from reset once a legal, terminated program is stored.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    instr_mem_loader_if.slave bus,
    output logic              cpu_rst_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        err_o,
    output logic [ADDR_W:0]   word_cnt_o
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    ld_state_e         state_q;
    ld_err_e           err_q;
    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] acc_d;
    logic [1:0]        idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] im_addr_q;
    logic [WORD_W-1:0] im_data_q;
    logic [ADDR_W:0]   cnt_q;
    logic              ready_q;
    logic              we_q;
    logic              cpu_rst_n_q;
    logic              busy_q;
    logic              done_q;

    logic              take_c;
    logic              op_ok_c;
    logic              funct_ok_c;
    logic              wr_stop_c;
    ld_err_e           wr_err_c;

    assign acc_d  = {acc_q[WORD_W-BYTE_W-1:0], bus.byte_i};
    assign take_c = bus.byte_valid_i & ready_q;

    isa_legal_check u_isa_chk (
        .word_i       (acc_q),
        .op_ok_c_o    (op_ok_c),
        .funct_ok_c_o (funct_ok_c)
    );

    // Outcome of the word being written; order encodes check priority.
    always_comb begin
        wr_stop_c = 1'b1;
        wr_err_c  = ERR_OK;
        if (acc_q == '0) begin
            wr_err_c = ERR_OK;
        end else if (!op_ok_c) begin
            wr_err_c = ERR_OPCODE;
        end else if ((opcode_of(acc_q) == OP_RTYPE) && !funct_ok_c) begin
            wr_err_c = ERR_FUNCT;
        end else if (addr_q == ADDR_LAST) begin
            wr_err_c = ERR_OVERFLOW;
        end else begin
            wr_stop_c = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            err_q       <= ERR_OK;
            acc_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            im_addr_q   <= '0;
            im_data_q   <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q     <= ST_RECV;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        cpu_rst_n_q <= 1'b0;
                        addr_q      <= '0;
                        idx_q       <= '0;
                        cnt_q       <= '0;
                        err_q       <= ERR_OK;
                    end
                end
                ST_RECV: begin
                    if (take_c) begin
                        acc_q <= acc_d;
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q   <= ST_WRITE;
                            ready_q   <= 1'b0;
                            we_q      <= 1'b1;
                            im_addr_q <= addr_q;
                            im_data_q <= acc_d;
                            cnt_q     <= cnt_q + (ADDR_W+1)'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_stop_c) begin
                        state_q     <= ST_DONE;
                        err_q       <= wr_err_c;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        cpu_rst_n_q <= (wr_err_c == ERR_OK);
                    end else begin
                        state_q <= ST_RECV;
                        addr_q  <= addr_q + ADDR_W'(1);
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.byte_ready_o = ready_q;
    assign bus.im_we_o      = we_q;
    assign bus.im_addr_o    = im_addr_q;
    assign bus.im_data_o    = im_data_q;
    assign cpu_rst_n_o      = cpu_rst_n_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign word_cnt_o       = cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a program-level model.
module tb_instr_mem_loader;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          cpu_rst_n, busy, done;
    logic [1:0]    err;
    logic [AW:0]   word_cnt;

    instr_mem_loader_if #(.ADDR_W(AW)) bus ();

    instr_mem_loader #(.ADDR_W(AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .bus         (bus),
        .cpu_rst_n_o (cpu_rst_n),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .word_cnt_o  (word_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int ready_in_write = 0;
    bit aborted = 0;

    logic [31:0]   prog [$];
    logic [AW+31:0] exp_w [$];
    logic [AW+31:0] got_w [$];
    logic [1:0]    exp_err;
    int            exp_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // IM write monitor, plus the rule that the loader never offers ready while writing
    always @(posedge clk) begin
        if (bus.im_we_o) got_w.push_back({bus.im_addr_o, bus.im_data_o});
        if (bus.im_we_o && bus.byte_ready_o) ready_in_write++;
    end

    function automatic bit op_legal(input logic [5:0] op);
        logic [5:0] ops [5] = '{6'h3F, 6'h37, 6'h3B, 6'h32, 6'h30};
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit fn_legal(input logic [5:0] fn);
        logic [5:0] fns [10] = '{6'h12, 6'h10, 6'h14, 6'h16, 6'h20,
                                 6'h06, 6'h00, 6'h04, 6'h02, 6'h15};
        foreach (fns[i]) if (fns[i] == fn) return 1'b1;
        return 1'b0;
    endfunction

    // kind: 0 legal, 1 illegal opcode, 2 R-type with illegal funct
    function automatic logic [31:0] gen_word(input int kind);
        logic [31:0] w;
        logic [5:0]  op, fn;
        w = $urandom;
        if (kind == 1) begin
            do op = 6'($urandom); while (op_legal(op));
            w[31:26] = op;
        end else if (kind == 2) begin
            do fn = 6'($urandom); while (fn_legal(fn));
            w[31:26] = 6'h3F;
            w[5:0]   = fn;
        end else begin
            do op = 6'($urandom); while (!op_legal(op));
            w[31:26] = op;
            if (op == 6'h3F) begin
                do fn = 6'($urandom); while (!fn_legal(fn));
                w[5:0] = fn;
            end
        end
        return w;
    endfunction

    // Expected writes and outcome for the program in prog
    task automatic model_run();
        exp_w.delete();
        exp_err = 2'b00;
        foreach (prog[i]) begin
            exp_w.push_back({AW'(i), prog[i]});
            if (prog[i] == 32'h0) begin exp_err = 2'b00; break; end
            if (!op_legal(prog[i][31:26])) begin exp_err = 2'b01; break; end
            if (prog[i][31:26] == 6'h3F && !fn_legal(prog[i][5:0])) begin exp_err = 2'b10; break; end
            if (i == DEPTH - 1) begin exp_err = 2'b11; break; end
        end
        exp_cnt = exp_w.size();
    endtask

    // mode: 0 always valid, 1 valid toggles each cycle, 2 random valid
    task automatic send_byte(input logic [7:0] b, input int mode);
        bit taken = 0;
        bit tog = 1;
        int tries = 0;
        while (!taken && !aborted) begin
            bus.byte_i = b;
            case (mode)
                1:       bus.byte_valid_i = tog;
                2:       bus.byte_valid_i = 1'($urandom_range(0, 1));
                default: bus.byte_valid_i = 1'b1;
            endcase
            tog = ~tog;
            @(negedge clk);
            taken = bus.byte_valid_i && bus.byte_ready_o;
            @(posedge clk); #1;
            tries++;
            if (!taken && tries > 64) begin
                check_eq("byte_accept_timeout", 64'd0, 64'd1);
                aborted = 1;
            end
        end
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_load(input string tag, input int mode);
        int wait_cyc = 0;
        model_run();
        got_w.delete();
        aborted = 0;
        pulse_start();
        check_eq({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        check_eq({tag, "_cpu_rst_after_start"}, 64'(cpu_rst_n), 64'd0);
        foreach (exp_w[i])
            for (int k = 3; k >= 0; k--)
                send_byte(exp_w[i][8*k +: 8], mode);
        while (!done && wait_cyc < 20) begin @(negedge clk); wait_cyc++; end
        @(negedge clk);
        check_eq({tag, "_done"}, 64'(done), 64'd1);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_err"}, 64'(err), 64'(exp_err));
        check_eq({tag, "_word_cnt"}, 64'(word_cnt), 64'(exp_cnt));
        check_eq({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'(exp_err == 2'b00));
        check_eq({tag, "_n_writes"}, 64'(got_w.size()), 64'(exp_w.size()));
        foreach (got_w[i])
            if (i < exp_w.size()) check_eq({tag, "_write"}, 64'(got_w[i]), 64'(exp_w[i]));
        @(posedge clk); #1;
    endtask

    initial begin
        int kind;
        int len;
        bus.byte_i       = 8'h00;
        bus.byte_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check_eq("rst_im_we", 64'(bus.im_we_o), 64'd0);
        check_eq("rst_ready", 64'(bus.byte_ready_o), 64'd0);
        check_eq("rst_done_busy_err", 64'({done, busy, err}), 64'd0);
        check_eq("rst_word_cnt", 64'(word_cnt), 64'd0);
        @(posedge clk); #1;

        prog = '{32'hDC000005, 32'h0};
        run_load("addi_term", 0);
        prog = '{32'hDC000005, 32'h0};
        run_load("addi_term_toggle", 1);
        prog = '{32'h04000000};
        run_load("bad_opcode", 0);
        prog = '{32'hFC221812, 32'hFC221807};
        run_load("bad_funct", 2);

        prog.delete();
        for (int i = 0; i < DEPTH; i++) prog.push_back(gen_word(0));
        run_load("overflow", 0);
        prog.delete();
        for (int i = 0; i < DEPTH - 1; i++) prog.push_back(gen_word(0));
        prog.push_back(32'h0);
        run_load("term_at_last", 0);

        // reset in the middle of the second word
        prog = '{32'hC0001234, 32'hFC221812, 32'h0};
        model_run();
        aborted = 0;
        pulse_start();
        for (int k = 3; k >= 0; k--) send_byte(prog[0][8*k +: 8], 0);
        send_byte(8'hFC, 0);
        send_byte(8'h22, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_im_we", 64'(bus.im_we_o), 64'd0);
        check_eq("midrst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check_eq("midrst_busy_ready", 64'({busy, bus.byte_ready_o}), 64'd0);
        check_eq("midrst_word_cnt", 64'(word_cnt), 64'd0);
        @(posedge clk); #1;
        run_load("after_rst", 0);

        for (int t = 0; t < 15; t++) begin
            prog.delete();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                kind = $urandom_range(0, 99);
                prog.push_back(gen_word(kind < 86 ? 0 : (kind < 93 ? 1 : 2)));
            end
            prog.push_back(32'h0);
            run_load("random", $urandom_range(0, 2));
        end

        check_eq("ready_during_write", 64'(ready_in_write), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
